// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority with a starvation-forced loader grant.
// Optional performance counters are enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [1:0]    cpu_store_type,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    input  logic [1:0]    ld_store_type,
    output logic          ld_rvalid,
    output logic [31:0]   ld_rdata,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]   stall_cnt,
    output logic [31:0]   ld_xfer_cnt,
`endif
    output logic          mem_we,
    output logic [1:0]    mem_store_type,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {
        ST_PRI   = 1'b0,
        ST_FORCE = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            ld_rvalid_q, ld_rvalid_d;
    logic [31:0]     ld_rdata_q, ld_rdata_d;
    logic            grant_cpu, grant_ld;

    // Grant decode, memory mux and next-state logic
    always_comb begin
        grant_cpu      = 1'b0;
        grant_ld       = 1'b0;
        state_d        = state_q;
        mem_we         = 1'b0;
        mem_store_type = 2'b10;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            ST_PRI: begin
                grant_cpu = cpu_req;
                grant_ld  = ld_valid & ~cpu_req;
            end
            ST_FORCE: begin
                grant_ld  = ld_valid;
                grant_cpu = cpu_req & ~ld_valid;
            end
            default: ;
        endcase

        if (grant_cpu) begin
            mem_we         = cpu_we;
            mem_store_type = cpu_store_type;
            mem_addr       = cpu_addr;
            mem_wdata      = cpu_wdata;
        end else if (grant_ld) begin
            mem_we         = ld_we;
            mem_store_type = ld_store_type;
            mem_addr       = ld_addr;
            mem_wdata      = ld_wdata;
        end

        if (grant_ld || !ld_valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        // The counter hitting the limit flips state on the same edge, so LD wins next cycle
        case (state_q)
            ST_PRI:   if (wait_cnt_d >= LIMIT) state_d = ST_FORCE;
            ST_FORCE: if (grant_ld || !ld_valid) state_d = ST_PRI;
            default:  state_d = ST_PRI;
        endcase

        ld_rvalid_d = grant_ld & ~ld_we;
        ld_rdata_d  = ld_rvalid_d ? mem_rdata : ld_rdata_q;
    end

    assign ld_ready  = grant_ld;
    assign cpu_stall = cpu_req & ~grant_cpu;
    assign cpu_rdata = mem_rdata;
    assign ld_rvalid = ld_rvalid_q;
    assign ld_rdata  = ld_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_PRI;
            wait_cnt_q  <= '0;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            ld_rvalid_q <= ld_rvalid_d;
            ld_rdata_q  <= ld_rdata_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] ld_xfer_cnt_q, ld_xfer_cnt_d;

    // Free-running event counters, wrapping at 2^32
    always_comb begin
        stall_cnt_d   = stall_cnt_q + 32'(cpu_stall);
        ld_xfer_cnt_d = ld_xfer_cnt_q + 32'(grant_ld);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q   <= '0;
            ld_xfer_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            ld_xfer_cnt_q <= ld_xfer_cnt_d;
        end
    end

    assign stall_cnt   = stall_cnt_q;
    assign ld_xfer_cnt = ld_xfer_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural dmem.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  cpu_store_type;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ld_valid, ld_ready, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic [1:0]  ld_store_type;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_we;
    logic [1:0]  mem_store_type;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt, ld_xfer_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] tmem [0:255];

    dmem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_store_type (cpu_store_type),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_wdata       (ld_wdata),
        .ld_store_type  (ld_store_type),
        .ld_rvalid      (ld_rvalid),
        .ld_rdata       (ld_rdata),
`ifdef DMEM_ARB_PERF_EN
        .stall_cnt      (stall_cnt),
        .ld_xfer_cnt    (ld_xfer_cnt),
`endif
        .mem_we         (mem_we),
        .mem_store_type (mem_store_type),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dmem: combinational read, byte-lane writes at the clock edge
    assign mem_rdata = tmem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_store_type)
                2'b00:   tmem[mem_addr[9:2]][8*mem_addr[1:0] +: 8]  <= mem_wdata[7:0];
                2'b01:   tmem[mem_addr[9:2]][16*mem_addr[1] +: 16]  <= mem_wdata[15:0];
                default: tmem[mem_addr[9:2]]                        <= mem_wdata;
            endcase
        end
    end

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_store_type = 2'b10;
        ld_valid = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_store_type = 2'b10;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        #2;
        total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", ld_rvalid); end
        total++; if (ld_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", ld_rdata); end
        total++; if (mem_store_type !== 2'b10 || mem_we !== 1'b0 || mem_addr !== 32'h0)
            begin bad++; $display("FAIL reset_idle_mux got=%b/%b/%h exp=10/0/0", mem_store_type, mem_we, mem_addr); end
        cpu_req = 1; ld_valid = 1; #1;
        total++; if (cpu_stall !== 1'b0 || ld_ready !== 1'b0)
            begin bad++; $display("FAIL reset_pri_grant got stall=%0b ready=%0b exp 0/0", cpu_stall, ld_ready); end
        idle_inputs();
        @(posedge clk); #1 reset = 1;
        next_cycle();
    endtask

    task automatic test_cpu_store();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF; cpu_store_type = 2'b10;
        #1;
        total++; if (mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL cpu_store_mux got we=%0b a=%h d=%h exp 1/40/deadbeef", mem_we, mem_addr, mem_wdata); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL cpu_store_stall got=%0b exp=0", cpu_stall); end
        next_cycle();
        cpu_we = 0; #1;
        total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_load_rdata got=%h exp=deadbeef", cpu_rdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL cpu_load_we got=%0b exp=0", mem_we); end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_ld_read();
        ld_valid = 1; ld_we = 0; ld_addr = 32'h40; #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL ld_read_ready got=%0b exp=1", ld_ready); end
        total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL ld_read_addr got=%h exp=40", mem_addr); end
        next_cycle();
        ld_valid = 0;
        total++; if (ld_rvalid !== 1'b1 || ld_rdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL ld_read_ret got v=%0b d=%h exp 1/deadbeef", ld_rvalid, ld_rdata); end
        next_cycle();
        total++; if (ld_rvalid !== 1'b0 || ld_rdata !== 32'hDEADBEEF)
            begin bad++; $display("FAIL ld_read_hold got v=%0b d=%h exp 0/deadbeef", ld_rvalid, ld_rdata); end
        idle_inputs();
    endtask

    task automatic test_ld_burst();
        logic [31:0] addrs [0:3];
        logic [31:0] datas [0:3];
        logic [1:0]  types [0:3];
        logic [31:0] exp_w [0:2];
        addrs = '{32'h100, 32'h104, 32'h108, 32'h105};
        datas = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h000000AB};
        types = '{2'b10, 2'b10, 2'b10, 2'b00};
        exp_w = '{32'h11111111, 32'h2222AB22, 32'h33333333};
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1; ld_we = 1; ld_addr = addrs[i]; ld_wdata = datas[i]; ld_store_type = types[i];
            #1;
            total++; if (ld_ready !== 1'b1 || mem_we !== 1'b1 || mem_store_type !== types[i])
                begin bad++; $display("FAIL ld_burst_%0d got rdy=%0b we=%0b t=%b exp 1/1/%b", i, ld_ready, mem_we, mem_store_type, types[i]); end
            next_cycle();
            total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL ld_burst_rvalid_%0d got=%0b exp=0", i, ld_rvalid); end
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; cpu_addr = 32'h100 + 32'(4 * i); #1;
            total++; if (cpu_rdata !== exp_w[i])
                begin bad++; $display("FAIL ld_burst_readback_%0d got=%h exp=%h", i, cpu_rdata, exp_w[i]); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp_ld;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        ld_valid = 1; ld_we = 0; ld_addr = 32'h104;
        for (int i = 0; i < 15; i++) begin
            exp_ld = ((i % 5) == 4);
            #1;
            total++; if (ld_ready !== exp_ld || cpu_stall !== exp_ld)
                begin bad++; $display("FAIL contention_%0d got rdy=%0b stall=%0b exp %0b/%0b", i, ld_ready, cpu_stall, exp_ld, exp_ld); end
            total++; if (mem_addr !== (exp_ld ? 32'h104 : 32'h40))
                begin bad++; $display("FAIL contention_addr_%0d got=%h exp=%h", i, mem_addr, exp_ld ? 32'h104 : 32'h40); end
            next_cycle();
            total++; if (ld_rvalid !== exp_ld)
                begin bad++; $display("FAIL contention_rvalid_%0d got=%0b exp=%0b", i, ld_rvalid, exp_ld); end
            if (exp_ld) begin
                total++; if (ld_rdata !== 32'h2222AB22)
                    begin bad++; $display("FAIL contention_rdata_%0d got=%h exp=2222ab22", i, ld_rdata); end
            end
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_wait_drop();
        // Three waits, one idle loader cycle clears the count, so four fresh waits follow
        cpu_req = 1; cpu_addr = 32'h40; ld_valid = 1; ld_addr = 32'h40;
        for (int i = 0; i < 3; i++) next_cycle();
        ld_valid = 0; next_cycle();
        ld_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (ld_ready !== (i == 4))
                begin bad++; $display("FAIL wait_drop_%0d got rdy=%0b exp=%0b", i, ld_ready, (i == 4)); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_in_force();
        cpu_req = 1; cpu_addr = 32'h40; ld_valid = 1; ld_we = 0; ld_addr = 32'h40;
        for (int i = 0; i < 4; i++) next_cycle();
        #1;
        total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rst_force_pre got=%0b exp=1", ld_ready); end
        reset = 0; #1;
        total++; if (ld_ready !== 1'b0 || cpu_stall !== 1'b0)
            begin bad++; $display("FAIL rst_force_grant got rdy=%0b stall=%0b exp 0/0", ld_ready, cpu_stall); end
        next_cycle();
        total++; if (ld_rvalid !== 1'b0) begin bad++; $display("FAIL rst_force_rvalid got=%0b exp=0", ld_rvalid); end
        reset = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (ld_ready !== (i == 4) || cpu_stall !== (i == 4))
                begin bad++; $display("FAIL rst_force_after_%0d got rdy=%0b stall=%0b exp=%0b", i, ld_ready, cpu_stall, (i == 4)); end
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

`ifdef DMEM_ARB_PERF_EN
    task automatic test_perf();
        reset = 0; idle_inputs(); next_cycle(); reset = 1; next_cycle();
        total++; if (stall_cnt !== 32'd0 || ld_xfer_cnt !== 32'd0)
            begin bad++; $display("FAIL perf_reset got %0d/%0d exp 0/0", stall_cnt, ld_xfer_cnt); end
        cpu_req = 1; cpu_addr = 32'h40; ld_valid = 1; ld_addr = 32'h40;
        for (int i = 0; i < 50; i++) next_cycle();
        total++; if (stall_cnt !== 32'd10 || ld_xfer_cnt !== 32'd10)
            begin bad++; $display("FAIL perf_counts got stall=%0d xfer=%0d exp 10/10", stall_cnt, ld_xfer_cnt); end
        idle_inputs();
        next_cycle();
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
        test_reset();
        test_cpu_store();
        test_ld_read();
        test_ld_burst();
        test_contention();
        test_wait_drop();
        test_reset_in_force();
`ifdef DMEM_ARB_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between the pipelined core's memory stage (CPU) and a secondary loader/DMA master (LD), which is used for program preload, debug access and test injection.
- Sits between riscv/dmem in the top level and drives dmem's write enable, store type, address and write data.
- The CPU has priority. A starvation counter guarantees LD forward progress, and the CPU receives a stall whenever it loses arbitration.
- Loader read data is registered and returned one cycle after the handshake.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles LD may wait with ld_valid high before it is force-granted. Legal range 1..255.
- AW, 32: address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  memory-stage access valid (load or store).
- cpu_we  in  1  1 = store.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  32  store data.
- cpu_store_type  in  2  00 byte, 01 half, 10 word.
- cpu_rdata  out  32  load data, combinational from mem_rdata.
- cpu_stall  out  1  hold the pipeline this cycle.
- ld_valid  in  1  loader request.
- ld_ready  out  1  loader request accepted this cycle.
- ld_we  in  1  1 = write.
- ld_addr  in  AW  byte address.
- ld_wdata  in  32  write data.
- ld_store_type  in  2  encoded as for cpu_store_type.
- ld_rvalid  out  1  registered read data valid.
- ld_rdata  out  32  registered read data.
- mem_we  out  1  to dmem.
- mem_store_type  out  2  to dmem.
- mem_addr  out  AW  to dmem.
- mem_wdata  out  32  to dmem.
- mem_rdata  in  32  from dmem (combinational read).

Behaviour:
- FSM states:
  - PRI: CPU has priority.
  - FORCE: LD has priority.
- Grant, combinational:
  - In PRI: grant_cpu = cpu_req; grant_ld = ld_valid & ~cpu_req.
  - In FORCE: grant_ld = ld_valid; grant_cpu = cpu_req & ~ld_valid.
- Port outputs:
  - ld_ready = grant_ld.
  - cpu_stall = cpu_req & ~grant_cpu.
- Memory mux:
  - When granted, mem_* carries the granted master's fields.
  - With no grant, mem_we = 0, mem_addr = 0, mem_wdata = 0 and mem_store_type = 10.
- cpu_rdata = mem_rdata every cycle. It is meaningful only when grant_cpu & ~cpu_we.
- wait_cnt (8-bit) updates each cycle:
  - Cleared when grant_ld or ~ld_valid.
  - Otherwise increments.
  - Saturates at STARVE_LIMIT.
- State transitions:
  - PRI -> FORCE when wait_cnt reaches STARVE_LIMIT (registered). The next cycle therefore grants LD.
  - FORCE -> PRI after exactly one LD handshake (grant_ld).
  - FORCE -> PRI also if ld_valid drops, without a handshake.
- Forced LD grant sequence: the cycle-level order is N waits, 1 forced LD grant, then CPU priority again. LD therefore cannot monopolise the port; the worst-case CPU stall from arbitration is 1 cycle per STARVE_LIMIT+1 cycles.
- Loader read return: a read handshake (grant_ld & ~ld_we) registers ld_rdata <= mem_rdata and sets ld_rvalid = 1 for exactly the next cycle. Back-to-back reads produce back-to-back rvalid.
- ld_rdata holds its last value when ld_rvalid = 0.
- Writes complete at the dmem clock edge in the granted cycle. There is no write response.
- Loader protocol: ld_valid and its fields stay stable until ld_ready. The arbiter does not check this; violations are undefined.
- Reset (low, asynchronous):
  - State = PRI, wait_cnt = 0, ld_rvalid = 0, ld_rdata = 0.
  - Combinational outputs follow the inputs from the PRI state.
  - A reset mid-transaction drops any pending LD request; no late rvalid is produced.
- Simultaneous events:
  - cpu_req and ld_valid together in PRI with wait_cnt < STARVE_LIMIT: CPU wins.
  - Both together in FORCE: LD wins.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined, adds two output ports:
  - stall_cnt  out  32: counts cycles with cpu_stall = 1.
  - ld_xfer_cnt  out  32: counts LD handshakes.
- Both counters wrap at 2^32 and are cleared by reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- CPU store alone: cpu_req=1, cpu_we=1, addr 0x40, wdata 0xDEADBEEF, type 10 -> same cycle mem_we=1, mem_addr=0x40, cpu_stall=0; readback load returns 0xDEADBEEF on cpu_rdata.
- LD read alone: ld_valid=1, ld_we=0, addr 0x40 -> ld_ready=1 that cycle; next cycle ld_rvalid=1, ld_rdata=0xDEADBEEF; the cycle after, ld_rvalid=0.
- Contention, STARVE_LIMIT=4: cpu_req and ld_valid held high -> ld_ready=0 for 4 cycles; 5th cycle ld_ready=1 and cpu_stall=1; 6th cycle CPU granted again and the pattern repeats.
- LD burst of 3 writes (0x100, 0x104, 0x108) with cpu_req=0 -> ld_ready=1 on 3 consecutive cycles; 3 words written; no rvalid.
- Reset pulled low during a FORCE cycle with ld_valid=1 -> state returns to PRI, ld_rvalid=0, wait_cnt=0; after release with both requesting, CPU is granted first.
- With DMEM_ARB_PERF_EN: the contention scenario run for 10 forced grants -> stall_cnt=10, ld_xfer_cnt=10.
